// File: rtl/serial_cmd_tx.sv
// Bus-programmed byte transmitter: CPU writes land in a 2-entry holding buffer and are
// framed (start, data LSB first, optional even parity, stop) onto o_sdwr with o_sclk/o_sfrm.
module serial_cmd_tx #(
  parameter int CLK_DIV   = 4,
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sser,
  input  logic [5:0]        i_ba,
  input  logic              i_br_w,
  input  logic              i_bstb,
  input  logic [DATA_W-1:0] i_bd_in,
  output logic [DATA_W-1:0] o_bd_out,
  output logic              o_bd_oe,
  output logic              o_sdwr,
  output logic              o_sclk,
  output logic              o_sfrm,
  output logic              o_irq
);

  localparam int DIV_W = 8;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [3:0] IDX_DATA = 4'd0;
  localparam logic [3:0] IDX_CTRL = 4'd1;
  localparam logic [3:0] IDX_STAT = 4'd2;

  // state  | meaning
  // IDLE   | line high, waiting for tx_en and buffered data
  // START  | start bit, sdwr low
  // DATA   | data bits LSB first, r_bit selects the bit
  // PARITY | even parity over the frame data (PARITY_EN only)
  // STOP   | stop bit, sdwr high; may chain straight into START
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic              w_sel;
  logic              w_acc;
  logic [3:0]        w_idx;
  logic              w_wr_data;
  logic              w_wr_ctrl;
  logic              w_rd_stat;

  logic [DATA_W-1:0] r_mem [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ovr_set;
  logic              r_ovr;

  logic [1:0]        r_ctrl;
  logic [1:0]        w_ctrl_nxt;
  logic              w_tx_en;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic              w_div_tc;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;

  logic              r_sdwr;
  logic              r_sclk;
  logic              r_sfrm;
  logic              r_irq;
  logic              w_sdwr_nxt;
  logic              w_sclk_nxt;
  logic              w_sfrm_nxt;
  logic              w_irq_nxt;

  assign w_sel     = ~i_sser & ~i_ba[5] & i_ba[4];
  assign w_acc     = i_bstb & w_sel;
  assign w_idx     = i_ba[3:0];
  assign w_wr_data = w_acc & ~i_br_w & (w_idx == IDX_DATA);
  assign w_wr_ctrl = w_acc & ~i_br_w & (w_idx == IDX_CTRL);
  assign w_rd_stat = w_acc &  i_br_w & (w_idx == IDX_STAT);

  assign w_full    = (r_count == 2'd2);
  assign w_empty   = (r_count == 2'd0);
  assign w_tx_en   = r_ctrl[0];
  assign w_ctrl_nxt = w_wr_ctrl ? i_bd_in[1:0] : r_ctrl;

  // A write into a full buffer still fits when the transmitter frees a slot that cycle.
  assign w_push    = w_wr_data & (~w_full | w_pop);
  assign w_ovr_set = w_wr_data & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_div_tc = (r_div == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_en && !w_empty) begin
          w_pop       = 1'b1;
          w_data_nxt  = r_mem[r_rd_ptr];
          w_state_nxt = ST_START;
          w_div_nxt   = DIV_LAST;
        end
      end
      ST_START: begin
        if (w_div_tc) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_div_nxt   = DIV_LAST;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (w_div_tc) begin
          w_div_nxt = DIV_LAST;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      ST_PARITY: begin
        if (w_div_tc) begin
          w_state_nxt = ST_STOP;
          w_div_nxt   = DIV_LAST;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (w_div_tc) begin
          w_div_nxt = DIV_LAST;
          if (w_tx_en && !w_empty) begin
            w_pop       = 1'b1;
            w_data_nxt  = r_mem[r_rd_ptr];
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_div_nxt   = DIV_LAST;
      end
    endcase
  end

  // Line outputs are registered from the next-state view so they line up with the state.
  always_comb begin
    w_sdwr_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_sdwr_nxt = 1'b0;
      ST_DATA:   w_sdwr_nxt = w_data_nxt[w_bit_nxt];
      ST_PARITY: w_sdwr_nxt = ^w_data_nxt;
      default:   w_sdwr_nxt = 1'b1;
    endcase
  end

  assign w_sfrm_nxt = (w_state_nxt != ST_IDLE);
  assign w_sclk_nxt = w_sfrm_nxt & (w_div_nxt < DIV_HALF);
  assign w_irq_nxt  = w_ctrl_nxt[1] & (w_count_nxt == 2'd0) & ~w_sfrm_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_div    <= DIV_LAST;
      r_bit    <= '0;
      r_data   <= '0;
      r_sdwr   <= 1'b1;
      r_sclk   <= 1'b0;
      r_sfrm   <= 1'b0;
      r_irq    <= 1'b0;
      r_ctrl   <= 2'b00;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_data  <= w_data_nxt;
      r_sdwr  <= w_sdwr_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sfrm  <= w_sfrm_nxt;
      r_irq   <= w_irq_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (w_rd_stat) r_ovr <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_bd_in;
  end

  assign o_bd_oe = w_acc & i_br_w;

  always_comb begin
    o_bd_out = '0;
    if (o_bd_oe) begin
      case (w_idx)
        IDX_CTRL: o_bd_out[1:0] = r_ctrl;
        IDX_STAT: o_bd_out[3:0] = {r_ovr, w_empty, w_full, r_sfrm};
        default:  o_bd_out = '0;
      endcase
    end
  end

  assign o_sdwr = r_sdwr;
  assign o_sclk = r_sclk;
  assign o_sfrm = r_sfrm;
  assign o_irq  = r_irq;

endmodule

// File: tb/tb_serial_cmd_tx.sv
// Testbench for serial_cmd_tx: scenario tasks with random bytes, compared against a
// frame model built from the bit-time arithmetic of the serial format.
module tb_serial_cmd_tx;

  localparam int CLK_DIV   = 4;
  localparam int DATA_W    = 8;
  localparam int PARITY_EN = 1;
  localparam int FRAME     = CLK_DIV * (DATA_W + 2 + PARITY_EN);
  localparam logic [3:0] IDX_DATA = 4'd0;
  localparam logic [3:0] IDX_CTRL = 4'd1;
  localparam logic [3:0] IDX_STAT = 4'd2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       sser  = 1'b1;
  logic [5:0] ba    = 6'd0;
  logic       br_w  = 1'b1;
  logic       bstb  = 1'b0;
  logic [7:0] bd_in = 8'd0;
  logic [7:0] bd_out;
  logic       bd_oe;
  logic       sdwr;
  logic       sclk;
  logic       sfrm;
  logic       irq;

  serial_cmd_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .PARITY_EN(PARITY_EN)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sser  (sser),
    .i_ba    (ba),
    .i_br_w  (br_w),
    .i_bstb  (bstb),
    .i_bd_in (bd_in),
    .o_bd_out(bd_out),
    .o_bd_oe (bd_oe),
    .o_sdwr  (sdwr),
    .o_sclk  (sclk),
    .o_sfrm  (sfrm),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic cap_sdwr [FRAME];
  logic cap_sclk [FRAME];
  logic cap_sfrm [FRAME];
  int   cap_start;
  bit   cap_timeout;
  int   last_bus_cyc;

  // Expected line level at cycle c of a frame carrying d.
  function automatic logic exp_sdwr(input logic [7:0] d, input int c);
    int k;
    k = c / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k <= DATA_W) return d[k-1];
    if (PARITY_EN != 0 && k == DATA_W + 1) return ^d;
    return 1'b1;
  endfunction

  function automatic int frame_mismatches(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (cap_sdwr[i] !== exp_sdwr(d, i) ||
          cap_sclk[i] !== ((i % CLK_DIV) >= CLK_DIV / 2) ||
          cap_sfrm[i] !== 1'b1) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] decode_byte();
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = cap_sdwr[(k + 1) * CLK_DIV + CLK_DIV / 2];
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Called at posedge+1; the strobe occupies exactly that cycle.
  task automatic bus_cycle(input logic sel_n, input logic [5:0] a, input logic rw,
                           input logic [7:0] wd, output logic [7:0] rd, output logic oe);
    sser = sel_n; ba = a; br_w = rw; bd_in = wd; bstb = 1'b1;
    last_bus_cyc = cyc;
    @(negedge clk);
    rd = bd_out;
    oe = bd_oe;
    @(posedge clk);
    #1;
    bstb = 1'b0; sser = 1'b1; ba = 6'd0; br_w = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [7:0] d);
    logic [7:0] rd;
    logic oe;
    bus_cycle(1'b0, {2'b01, idx}, 1'b0, d, rd, oe);
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [7:0] v);
    logic oe;
    bus_cycle(1'b0, {2'b01, idx}, 1'b1, 8'd0, v, oe);
  endtask

  task automatic wait_until(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 2000) begin
      step();
      g++;
    end
    checks++;
    if (cyc != target) begin
      errors++;
      $display("FAIL wait_until: reached cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic capture_frame();
    int n;
    n = 0;
    cap_timeout = 1'b0;
    @(negedge clk);
    while (sfrm !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_start = cyc;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      cap_sdwr[i] = sdwr;
      cap_sclk[i] = sclk;
      cap_sfrm[i] = sfrm;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    @(negedge clk);
    checks++;
    if ({sdwr, sclk, sfrm, irq} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_lines: got sdwr/sclk/sfrm/irq=%b required 1000", {sdwr, sclk, sfrm, irq});
    end
    checks++;
    if (bd_oe !== 1'b0 || bd_out !== 8'h00) begin
      errors++;
      $display("FAIL idle_bus: got oe=%b out=%h required oe=0 out=00", bd_oe, bd_out);
    end
    step();
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL reset_stat: got %h required 04", v); end
    bus_read(IDX_CTRL, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h required 00", v); end
  endtask

  task automatic test_decode();
    logic [7:0] v;
    logic oe;
    do_reset();
    bus_cycle(1'b1, {2'b01, IDX_CTRL}, 1'b0, 8'h03, v, oe);
    bus_cycle(1'b0, {2'b11, IDX_CTRL}, 1'b0, 8'h03, v, oe);
    bus_cycle(1'b1, {2'b01, IDX_CTRL}, 1'b1, 8'h00, v, oe);
    checks++;
    if (oe !== 1'b0 || v !== 8'h00) begin
      errors++;
      $display("FAIL unselected_read: got oe=%b data=%h required oe=0 data=00", oe, v);
    end
    bus_read(IDX_CTRL, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL ignored_ctrl_write: got %h required 00", v); end
    bus_cycle(1'b0, {2'b01, 4'd7}, 1'b1, 8'h00, v, oe);
    checks++;
    if (oe !== 1'b1 || v !== 8'h00) begin
      errors++;
      $display("FAIL unlisted_read: got oe=%b data=%h required oe=1 data=00", oe, v);
    end
    bus_write(IDX_CTRL, 8'hFE);
    bus_read(IDX_CTRL, v);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL ctrl_readback: got %h required 02", v); end
  endtask

  task automatic test_single_frame();
    int n0, nm;
    logic [7:0] got;
    do_reset();
    bus_write(IDX_CTRL, 8'h01);
    bus_write(IDX_DATA, 8'hA5);
    n0 = last_bus_cyc;
    @(negedge clk);
    checks++;
    if (sfrm !== 1'b0 || sdwr !== 1'b1) begin
      errors++;
      $display("FAIL latency_n1: got sfrm=%b sdwr=%b at N+1 required 0/1", sfrm, sdwr);
    end
    capture_frame();
    checks++;
    if (cap_timeout || cap_start != n0 + 2) begin
      errors++;
      $display("FAIL latency_start: got start %0d (timeout=%0d) required %0d", cap_start, cap_timeout, n0 + 2);
    end
    nm = frame_mismatches(8'hA5);
    checks++;
    if (nm !== 0) begin errors++; $display("FAIL a5_wave: got %0d bad cycles required 0", nm); end
    got = decode_byte();
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h required a5", got); end
    @(negedge clk);
    checks++;
    if (sfrm !== 1'b0 || sdwr !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL a5_end: got sfrm=%b sdwr=%b sclk=%b required 0/1/0", sfrm, sdwr, sclk);
    end
  endtask

  task automatic test_random_frames();
    int n0, nm;
    logic [7:0] d, got;
    do_reset();
    bus_write(IDX_CTRL, 8'h01);
    for (int t = 0; t < 4; t++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) step();
      bus_write(IDX_DATA, d);
      n0 = last_bus_cyc;
      capture_frame();
      checks++;
      if (cap_timeout || cap_start != n0 + 2) begin
        errors++;
        $display("FAIL rand_start: got %0d required %0d", cap_start, n0 + 2);
      end
      nm = frame_mismatches(d);
      got = decode_byte();
      checks++;
      if (nm !== 0 || got !== d) begin
        errors++;
        $display("FAIL rand_frame: got data %h with %0d bad cycles required %h", got, nm, d);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int s1, nm;
    logic [7:0] v, got;
    do_reset();
    bus_write(IDX_CTRL, 8'h01);
    bus_write(IDX_DATA, 8'h01);
    bus_write(IDX_DATA, 8'h80);
    capture_frame();
    s1 = cap_start;
    nm = frame_mismatches(8'h01);
    checks++;
    if (cap_timeout || nm !== 0) begin errors++; $display("FAIL b2b_frame1: got %0d bad cycles required 0", nm); end
    fork
      capture_frame();
      begin
        repeat (5) step();
        bus_read(IDX_STAT, v);
      end
    join
    checks++;
    if (cap_timeout || cap_start != s1 + FRAME) begin
      errors++;
      $display("FAIL b2b_gap: got frame2 start %0d required %0d", cap_start, s1 + FRAME);
    end
    nm = frame_mismatches(8'h80);
    got = decode_byte();
    checks++;
    if (nm !== 0 || got !== 8'h80) begin
      errors++;
      $display("FAIL b2b_frame2: got %h with %0d bad cycles required 80", got, nm);
    end
    checks++;
    if (v !== 8'h05) begin errors++; $display("FAIL b2b_stat: got %h required 05", v); end
  endtask

  task automatic test_overflow();
    int nm;
    logic [7:0] v, got;
    do_reset();
    bus_write(IDX_DATA, 8'h11);
    bus_write(IDX_DATA, 8'h22);
    bus_write(IDX_DATA, 8'h33);
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h0A) begin errors++; $display("FAIL ovr_stat1: got %h required 0a", v); end
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h02) begin errors++; $display("FAIL ovr_stat2: got %h required 02", v); end
    bus_write(IDX_CTRL, 8'h01);
    capture_frame();
    nm = frame_mismatches(8'h11);
    got = decode_byte();
    checks++;
    if (cap_timeout || nm !== 0 || got !== 8'h11) begin
      errors++;
      $display("FAIL ovr_first: got %h with %0d bad cycles required 11", got, nm);
    end
    capture_frame();
    nm = frame_mismatches(8'h22);
    got = decode_byte();
    checks++;
    if (cap_timeout || nm !== 0 || got !== 8'h22) begin
      errors++;
      $display("FAIL ovr_second: got %h with %0d bad cycles required 22", got, nm);
    end
    step();
    step();
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL ovr_drained: got %h required 04", v); end
  endtask

  task automatic test_pop_collision();
    int n0, prev, nm;
    logic [7:0] bytes [4];
    logic [7:0] v, got;
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(0, 255));
    do_reset();
    bus_write(IDX_CTRL, 8'h01);
    fork
      capture_frame();
      begin
        bus_write(IDX_DATA, bytes[0]);
        n0 = last_bus_cyc;
        bus_write(IDX_DATA, bytes[1]);
        bus_write(IDX_DATA, bytes[2]);
        wait_until(n0 + 2 + FRAME - 1);
        bus_write(IDX_DATA, bytes[3]);
      end
    join
    prev = n0 + 2 - FRAME;
    for (int f = 0; f < 4; f++) begin
      if (f > 0) capture_frame();
      nm = frame_mismatches(bytes[f]);
      got = decode_byte();
      checks++;
      if (cap_timeout || nm !== 0 || got !== bytes[f] || cap_start != prev + FRAME) begin
        errors++;
        $display("FAIL collide_frame%0d: got %h start %0d (%0d bad cycles) required %h start %0d",
                 f, got, cap_start, nm, bytes[f], prev + FRAME);
      end
      prev = cap_start;
    end
    step();
    step();
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL collide_stat: got %h required 04", v); end
  endtask

  task automatic test_tx_en_clear();
    int nm, highs;
    logic [7:0] x, y, v, got;
    x = 8'($urandom_range(0, 255));
    y = 8'($urandom_range(0, 255));
    do_reset();
    bus_write(IDX_CTRL, 8'h01);
    bus_write(IDX_DATA, x);
    bus_write(IDX_DATA, y);
    fork
      capture_frame();
      begin
        repeat (10) step();
        bus_write(IDX_CTRL, 8'h00);
      end
    join
    nm = frame_mismatches(x);
    got = decode_byte();
    checks++;
    if (cap_timeout || nm !== 0 || got !== x) begin
      errors++;
      $display("FAIL txen_finish: got %h with %0d bad cycles required %h", got, nm, x);
    end
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sfrm !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL txen_hold: got %0d busy cycles required 0", highs); end
    step();
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL txen_retained: got %h required 00", v); end
    bus_write(IDX_CTRL, 8'h01);
    capture_frame();
    nm = frame_mismatches(y);
    got = decode_byte();
    checks++;
    if (cap_timeout || nm !== 0 || got !== y) begin
      errors++;
      $display("FAIL txen_resume: got %h with %0d bad cycles required %h", got, nm, y);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    logic [7:0] x, v;
    x = 8'($urandom_range(0, 255)) & 8'hF7;
    do_reset();
    bus_write(IDX_CTRL, 8'h01);
    bus_write(IDX_DATA, x);
    n0 = last_bus_cyc;
    bus_write(IDX_DATA, ~x);
    wait_until(n0 + 2 + 4 * CLK_DIV + 1);
    @(negedge clk);
    checks++;
    if (sfrm !== 1'b1 || sdwr !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: got sfrm=%b sdwr=%b in data bit 3 required 1/0", sfrm, sdwr);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sdwr, sfrm, sclk, irq} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_lines: got sdwr/sfrm/sclk/irq=%b required 1000", {sdwr, sfrm, sclk, irq});
    end
    step();
    bus_read(IDX_STAT, v);
    checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL midrst_stat: got %h required 04", v); end
    bus_read(IDX_CTRL, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL midrst_ctrl: got %h required 00", v); end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    do_reset();
    bus_write(IDX_CTRL, 8'h03);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable: got %b required 1", irq); end
    step();
    bus_write(IDX_DATA, d);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_write: got %b required 0", irq); end
    capture_frame();
    checks++;
    if (cap_timeout || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_in_stop: got %b (timeout=%0d) required 0", irq, cap_timeout);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", irq); end
    step();
    bus_write(IDX_DATA, ~d);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_next: got %b required 0", irq); end
    capture_frame();
    step();
    bus_write(IDX_CTRL, 8'h01);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b required 0", irq); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_overflow();
    test_pop_collision();
    test_tx_en_clear();
    test_reset_mid_frame();
    test_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
